// File: rtl/uart_msg_pkg.sv
// Shared types and default sizing for the UART message arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_msg_pkg;

  // Default geometry: 8-bit characters, 16-character messages.
  localparam int N_DEF      = 8;
  localparam int M_DEF      = 128;
  localparam int NCHAR      = M_DEF / N_DEF;
  localparam int IDX_W      = $clog2(NCHAR);
  localparam int ACK_TO_DEF = 1023;
  localparam int TO_W       = $clog2(ACK_TO_DEF + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_DONE
  } state_t;

  // Keeps derived vector widths legal when a parameter collapses to 1.
  function automatic int safe_w(input int w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_msg_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the pointer register lives in the parent.
// Ports: req (request levels), ptr (search start), pick_oh (one-hot winner),
//        pick_idx (encoded winner), pick_vld (any request present).
module rr_arbiter
  import uart_msg_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  pick_oh,
  output logic [PTR_W-1:0] pick_idx,
  output logic             pick_vld
);

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    // Walk NREQ positions starting at ptr; the first hit wins.
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_vld && req[(int'(ptr) + k) % NREQ]) begin
        pick_vld                           = 1'b1;
        pick_oh[(int'(ptr) + k) % NREQ]    = 1'b1;
        pick_idx                           = PTR_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/uart_msg_arbiter.sv
// Shares one UART TX among NREQ message sources; round-robin grant, NUL bytes skipped.
// Latency: grant one edge after req is seen in IDLE, first non-NUL enable one edge later.
// Backpressure: each char waits for busy to rise (or ACK_TO cycles) and then fall.
// Ports: clk/reset (sync, active-low); req, msg (flattened, source i at msg[i*M +: M],
//        MSB byte first); busy from TX; enable/bus to TX; grant (one-hot owner);
//        done (one-cycle pulse on the owner bit at message end).
module uart_msg_arbiter
  import uart_msg_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int M      = M_DEF,
  parameter int NREQ   = 4,
  parameter int ACK_TO = ACK_TO_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*M-1:0] msg,
  input  logic              busy,
  output logic              enable,
  output logic [N-1:0]      bus,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done
);

  localparam int NCHAR = M / N;
  localparam int IDX_W = safe_w($clog2(NCHAR));
  localparam int TO_W  = safe_w($clog2(ACK_TO + 1));
  localparam int PTR_W = safe_w($clog2(NREQ));

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHAR - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(ACK_TO);
  localparam logic [PTR_W-1:0] LAST_SRC = PTR_W'(NREQ - 1);

  state_t             state, state_nxt;
  logic [M-1:0]       shreg;
  logic [IDX_W-1:0]   idx;
  logic [TO_W-1:0]    to_cnt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic               to_seen;   // sticky: some char was released by timeout

  logic [NREQ-1:0]    pick_oh;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [M-1:0]       msg_arr [NREQ];

  // FSM control strobes
  logic ld_msg, adv, send, fin, to_hit, cnt_inc;

  logic [N-1:0] top_char;
  logic         top_nul;
  logic         last_char;

  assign top_char  = shreg[M-1 -: N];
  assign top_nul   = (top_char == '0);
  assign last_char = (idx == LAST_IDX);

  for (genvar g = 0; g < NREQ; g++) begin : g_msg
    assign msg_arr[g] = msg[g*M +: M];
  end

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req      (req),
    .ptr      (ptr),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_msg    = 1'b0;
    adv       = 1'b0;
    send      = 1'b0;
    fin       = 1'b0;
    to_hit    = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          ld_msg    = 1'b1;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (top_nul) begin
          if (last_char) begin
            fin       = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            adv = 1'b1;
          end
        end else begin
          send      = 1'b1;
          state_nxt = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (busy) begin
          state_nxt = ST_WAIT_LO;
        end else if (to_cnt == TO_MAX) begin
          to_hit    = 1'b1;
          state_nxt = ST_WAIT_LO;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!busy) begin
          if (last_char) begin
            fin       = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            adv       = 1'b1;
            state_nxt = ST_CHECK;
          end
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered; done and the grant drop are launched on the
  // edge entering DONE so both are visible during the DONE cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      enable  <= 1'b0;
      bus     <= '0;
      grant   <= '0;
      done    <= '0;
      ptr     <= '0;
      owner   <= '0;
      shreg   <= '0;
      idx     <= '0;
      to_cnt  <= '0;
      to_seen <= 1'b0;
    end else begin
      enable <= send;
      done   <= '0;
      if (ld_msg) begin
        grant <= pick_oh;
        owner <= pick_idx;
        shreg <= msg_arr[pick_idx];
        idx   <= '0;
      end
      if (adv) begin
        shreg <= shreg << N;
        idx   <= idx + IDX_W'(1);
      end
      if (send) begin
        bus    <= top_char;
        to_cnt <= '0;
      end
      if (cnt_inc) to_cnt  <= to_cnt + TO_W'(1);
      if (to_hit)  to_seen <= 1'b1;
      if (fin) begin
        done  <= grant;
        grant <= '0;
      end
      if (state == ST_DONE) ptr <= (owner == LAST_SRC) ? '0 : owner + PTR_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Directed bench for uart_msg_arbiter with a behavioural TX busy model.
// Latency: n/a.
// Backpressure: TX model holds busy for tx_len cycles starting one cycle after enable.
module tb_uart_msg_arbiter;
  import uart_msg_pkg::*;

  localparam int NREQ = 4;
  localparam int M    = 128;

  logic            clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [NREQ*M-1:0] msg;
  logic            busy;
  logic            enable;
  logic [7:0]      bus;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] done;

  int checks = 0;
  int errors = 0;

  uart_msg_arbiter #(.N(8), .M(M), .NREQ(NREQ), .ACK_TO(1023)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .msg    (msg),
    .busy   (busy),
    .enable (enable),
    .bus    (bus),
    .grant  (grant),
    .done   (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // TX model: busy rises the cycle after enable and lasts tx_len cycles.
  int tx_len = 0;
  int busy_left = 0;
  initial busy = 1'b0;
  always @(posedge clk) begin
    if (enable && tx_len != 0) begin
      busy      <= 1'b1;
      busy_left <= tx_len - 1;
    end else if (busy_left != 0) begin
      busy_left <= busy_left - 1;
    end else begin
      busy <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int en_cnt, nul_sent, en_gap, last_en_cyc, last_done_cyc, grant_rise_cyc, done_total, gi;
  int done_cnt [NREQ];
  logic [7:0] first_bus, last_bus;
  int grant_q [$];
  int gap_q [$];
  logic [7:0] bus_q [$];
  logic [NREQ-1:0] grant_d = '0;
  logic [NREQ-1:0] done_d = '0;

  always @(negedge clk) begin
    if (enable === 1'b1) begin
      en_cnt++;
      if (en_cnt == 1) first_bus = bus;
      last_bus = bus;
      if (bus == 8'h00) nul_sent++;
      en_gap = cyc - last_en_cyc;
      last_en_cyc = cyc;
      bus_q.push_back(bus);
    end
    if (done !== '0 && done !== 'x) begin
      done_total++;
      last_done_cyc = cyc;
      for (int i = 0; i < NREQ; i++) if (done[i]) done_cnt[i]++;
      chk("done_grant_drop", grant, 0);
      chk("done_onehot", $countones(done), 1);
      chk("done_single_pulse", done_d, 0);
    end
    if (grant !== '0 && grant !== 'x && grant_d == '0) begin
      gi = -1;
      for (int i = 0; i < NREQ; i++) if (grant[i]) gi = i;
      grant_q.push_back(gi);
      gap_q.push_back(cyc - last_done_cyc);
      grant_rise_cyc = cyc;
    end
    grant_d = (grant === 'x) ? '0 : grant;
    done_d  = (done === 'x) ? '0 : done;
  end

  task automatic clear_mon();
    en_cnt = 0; nul_sent = 0; done_total = 0; en_gap = 0;
    bus_q.delete(); grant_q.delete(); gap_q.delete();
    for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_msg(input int src, input logic [M-1:0] m);
    msg[src*M +: M] = m;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (grant == '0 && n < 200) begin tick(); n++; end
    chk(tag, grant != '0, 1);
  endtask

  task automatic wait_done(input int target, input int limit, input string tag);
    int n = 0;
    while (done_total < target && n < limit) begin tick(); n++; end
    tick();
    chk(tag, done_total >= target, 1);
  endtask

  function automatic int q_int(input int q [$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    string s;
    int n;
    int exp_rr [5] = '{0, 1, 2, 3, 0};
    last_en_cyc = 0; last_done_cyc = -100; grant_rise_cyc = 0;
    reset = 1'b0; req = '0; msg = '0;
    clear_mon();

    // Reset state
    repeat (2) tick();
    chk("rst_enable", enable, 0);
    chk("rst_bus", bus, 0);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_ptr", dut.ptr, 0);
    chk("rst_to_seen", dut.to_seen, 0);
    reset = 1'b1;
    tick();

    // 1: leading NUL skipped, 15 chars, 20-cycle busy
    clear_mon();
    tx_len = 20;
    set_msg(0, "Wake up, Neo...");
    req = 4'b0001;
    wait_grant("t1_grant_timeout");
    req = '0;
    wait_done(1, 2000, "t1_done_timeout");
    chk("t1_enables", en_cnt, 15);
    chk("t1_first_bus", first_bus, 8'h57);
    chk("t1_last_bus", last_bus, 8'h2E);
    chk("t1_nul_sent", nul_sent, 0);
    chk("t1_done0", done_cnt[0], 1);
    chk("t1_done_total", done_total, 1);

    // 2: round robin with all four held after reset
    reset = 1'b0; tick(); reset = 1'b1;
    clear_mon();
    tx_len = 1;
    set_msg(0, "A"); set_msg(1, "B"); set_msg(2, "C"); set_msg(3, "D");
    req = 4'b1111;
    n = 0;
    while (grant_q.size() < 5 && n < 500) begin tick(); n++; end
    req = '0;
    chk("t2_grant_timeout", grant_q.size() >= 5, 1);
    wait_done(5, 500, "t2_done_timeout");
    s = "ABCDA";
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_order%0d", i), q_int(grant_q, i), exp_rr[i]);
      chk($sformatf("t2_char%0d", i), (i < bus_q.size()) ? bus_q[i] : 8'hFF, s[i]);
    end
    // done cycle, one IDLE cycle, then the next grant
    for (int i = 1; i < 5; i++) chk($sformatf("t2_gap%0d", i), q_int(gap_q, i), 2);

    // 3: all-NUL message on source 2
    clear_mon();
    set_msg(2, '0);
    req = 4'b0100;
    wait_grant("t3_grant_timeout");
    req = '0;
    wait_done(1, 100, "t3_done_timeout");
    chk("t3_enables", en_cnt, 0);
    chk("t3_done2", done_cnt[2], 1);
    chk("t3_done_delay", last_done_cyc - grant_rise_cyc, 16);

    // 4: TX absent, every char released by timeout
    clear_mon();
    tx_len = 0;
    set_msg(1, "OK");
    req = 4'b0010;
    wait_grant("t4_grant_timeout");
    req = '0;
    wait_done(1, 5000, "t4_done_timeout");
    chk("t4_enables", en_cnt, 2);
    // enable cycle + 1023 wait cycles + WAIT_LO + CHECK
    chk("t4_en_gap", en_gap, 1026);
    chk("t4_done_delay", last_done_cyc - last_en_cyc, 1025);
    chk("t4_to_seen", dut.to_seen, 1);
    chk("t4_char1", (bus_q.size() > 1) ? bus_q[1] : 8'hFF, 8'h4B);
    chk("t4_ptr", dut.ptr, 2);

    // 5: reset in WAIT_LO of the sixth character
    clear_mon();
    tx_len = 20;
    set_msg(0, "0123456789ABCDEF");
    req = 4'b0001;
    n = 0;
    while (!(dut.state == ST_WAIT_LO && dut.idx == 5) && n < 1000) begin tick(); n++; end
    chk("t5_reach_timeout", (dut.state == ST_WAIT_LO && dut.idx == 5), 1);
    reset = 1'b0; req = '0;
    tick();
    reset = 1'b1;
    chk("t5_enable", enable, 0);
    chk("t5_bus", bus, 0);
    chk("t5_grant", grant, 0);
    chk("t5_done", done, 0);
    chk("t5_ptr", dut.ptr, 0);
    chk("t5_to_seen", dut.to_seen, 0);
    chk("t5_state", dut.state == ST_IDLE, 1);
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    repeat (3) tick();
    chk("t5_no_done", done_total, 0);
    clear_mon();
    req = 4'b1001;
    tick();
    chk("t5_regrant", grant, 4'b0001);
    tick();
    chk("t5_first_enable", enable, 1);
    chk("t5_first_bus", bus, 8'h30);
    req = '0;
    wait_done(1, 1000, "t5_done_timeout");
    chk("t5_enables", en_cnt, 16);
    chk("t5_last_bus", last_bus, 8'h46);
    chk("t5_done0", done_cnt[0], 1);

    // 6: snapshot survives msg change and req drop after grant
    clear_mon();
    tx_len = 1;
    set_msg(0, "HELLO");
    req = 4'b0001;
    wait_grant("t6_grant_timeout");
    tick();
    set_msg(0, "WORLD");
    req = '0;
    wait_done(1, 300, "t6_done_timeout");
    chk("t6_enables", en_cnt, 5);
    s = "HELLO";
    for (int i = 0; i < 5; i++)
      chk($sformatf("t6_char%0d", i), (i < bus_q.size()) ? bus_q[i] : 8'hFF, s[i]);
    chk("t6_min_char_period", en_gap, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
